// File: rtl/ps2_scan_event_rx.sv
// PS/2 keyboard receiver: sync + filter, 11-bit frame FSM, E0/F0 decoder, FWFT event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_scan_event_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    input  logic                        ps2_clk_in,
    input  logic                        ps2_dat_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_break,
    output logic                        evt_ext,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // bit 0 = clock line, bit 1 = data line
    logic [1:0]         s1_q, s2_q, filt_q;
    logic [1:0][FW-1:0] fcnt_q;
    logic               prev_q, fall_q, bit_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            filt_q <= 2'b11;
            fcnt_q <= '0;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
            bit_q  <= 1'b1;
        end else begin
            s1_q   <= {ps2_dat_in, ps2_clk_in};
            s2_q   <= s1_q;
            prev_q <= filt_q[0];
            fall_q <= prev_q & ~filt_q[0];
            if (prev_q & ~filt_q[0])
                bit_q <= filt_q[1];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          acc_q, acc_d;
    logic          err_q, err_d;
    logic          par_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        acc_d   = 1'b0;
        err_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE)
            tmo_d = fall_q ? '0 : tmo_q + 1'b1;
        // a stalled partial frame is dropped silently
        if (state_q != IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end else if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!bit_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = bit_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    if (bit_q && par_ok)
                        acc_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    logic ext_q, brk_q, push, pop, full, wr_en, ovf_q;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;

    assign push  = acc_q && shift_q != 8'hE0 && shift_q != 8'hF0;
    assign full  = lvl_q == LW'(FIFO_DEPTH);
    assign pop   = (lvl_q != '0) & evt_ready;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (acc_q) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (wr_en)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(wr_en) - LW'(pop);
            ovf_q <= push & full & ~pop;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem_q[wr_q] <= {ext_q, brk_q, shift_q};
    end

    assign evt_valid  = lvl_q != '0;
    assign {evt_ext, evt_break, evt_code} = evt_valid ? mem_q[rd_q] : 10'h000;
    assign fifo_level = lvl_q;
    assign overflow   = ovf_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_ps2_scan_event_rx.sv
// Bench for ps2_scan_event_rx: vector table, multi-cycle corner sequences,
// and random keystreams checked against a queue-based decoder model.
module tb_ps2_scan_event_rx;
    localparam int FL   = 8;
    localparam int TMO  = 2000;
    localparam int DEP  = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       evt_valid, evt_ready, evt_break, evt_ext, overflow, frame_err;
    logic [7:0] evt_code;
    logic [$clog2(DEP):0] fifo_level;

    ps2_scan_event_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEP)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_break(evt_break), .evt_ext(evt_ext), .fifo_level(fifo_level),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_err = 0;
    int n_ovf = 0;
    bit rnd_rdy = 0;
    logic [9:0] got_q[$];

    initial evt_ready = 1'b0;

    always @(negedge clk) begin
        if (evt_valid && evt_ready)
            got_q.push_back({evt_ext, evt_break, evt_code});
        if (frame_err) n_err++;
        if (overflow) n_ovf++;
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            evt_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 evt_ready = v;
    endtask

    task automatic send_bits(input logic [7:0] d, input bit bp, input bit bs, input int nb);
        logic [10:0] f;
        f = {~bs, (~^d) ^ bp, d, 1'b0};
        for (int i = 0; i < nb; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs);
        send_bits(d, bp, bs, 11);
        repeat (40) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         bp;
        bit         bs;
        int         n;
        logic [9:0] evt;
        int         err;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
        vt[1]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
        vt[2]  = '{8'h75, 0, 0, 1, 10'h375, 0};
        vt[3]  = '{8'h75, 0, 0, 1, 10'h075, 0};
        vt[4]  = '{8'h1C, 0, 0, 1, 10'h01C, 0};
`ifdef PS2_PARITY_CHECK_EN
        vt[5]  = '{8'h1C, 1, 0, 0, 10'h000, 1};
`else
        vt[5]  = '{8'h1C, 1, 0, 1, 10'h01C, 0};
`endif
        vt[6]  = '{8'h5A, 0, 1, 0, 10'h000, 1};
        vt[7]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
        vt[8]  = '{8'h6B, 0, 0, 1, 10'h26B, 0};
        vt[9]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
        vt[10] = '{8'h12, 0, 0, 1, 10'h112, 0};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_brk_ext", 32'({evt_break, evt_ext}), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pulses", 32'({overflow, frame_err}), 0);
        rst_n = 1'b1;
        set_ready(1);

        foreach (vt[k]) begin
            int e0, r0;
            e0 = got_q.size();
            r0 = n_err;
            send_frame(vt[k].d, vt[k].bp, vt[k].bs);
            chk($sformatf("vec%0d_nevt", k), 32'(got_q.size() - e0), 32'(vt[k].n));
            if (vt[k].n == 1 && got_q.size() > e0)
                chk($sformatf("vec%0d_evt", k), 32'(got_q[e0]), 32'(vt[k].evt));
            chk($sformatf("vec%0d_err", k), 32'(n_err - r0), 32'(vt[k].err));
        end
        chk("level_idle", 32'(fifo_level), 0);

        begin
            int o0;
            set_ready(0);
            got_q.delete();
            o0 = n_ovf;
            for (int i = 0; i <= DEP; i++)
                send_frame(8'h10 + 8'(i), 0, 0);
            @(negedge clk);
            chk("ovf_level", 32'(fifo_level), DEP);
            chk("ovf_pulses", 32'(n_ovf - o0), 1);
            chk("ovf_head", 32'({evt_valid, evt_code}), 32'h110);
            set_ready(1);
            repeat (20) @(posedge clk);
            chk("ovf_drained", 32'(got_q.size()), DEP);
            for (int i = 0; i < DEP && i < got_q.size(); i++)
                chk($sformatf("ovf_code%0d", i), 32'(got_q[i]), 32'h10 + 32'(i));
            @(negedge clk);
            chk("ovf_level_end", 32'(fifo_level), 0);
        end

        begin
            int r0;
            got_q.delete();
            r0 = n_err;
            send_bits(8'h55, 0, 0, 5);
            repeat (TMO + 10) @(posedge clk);
            send_frame(8'h29, 0, 0);
            chk("tmo_nevt", 32'(got_q.size()), 1);
            if (got_q.size() > 0)
                chk("tmo_evt", 32'(got_q[0]), 32'h029);
            chk("tmo_err", 32'(n_err - r0), 0);
        end

        begin
            logic [9:0] exp_q[$];
            logic ext, brk;
            logic [7:0] d;
            int r0, xerr, sz;
            bit bs;
            ext = 0;
            brk = 0;
            xerr = 0;
            got_q.delete();
            r0 = n_err;
            rnd_rdy = 1;
            for (int i = 0; i < 40; i++) begin
                int r;
                r = $urandom_range(0, 9);
                d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
                bs = ($urandom_range(0, 7) == 0);
                if (bs) begin
                    xerr++;
                end else if (d == 8'hE0) begin
                    ext = 1;
                end else if (d == 8'hF0) begin
                    brk = 1;
                end else begin
                    exp_q.push_back({ext, brk, d});
                    ext = 0;
                    brk = 0;
                end
                send_frame(d, 0, bs);
            end
            rnd_rdy = 0;
            set_ready(1);
            repeat (20) @(posedge clk);
            chk("rnd_nevt", 32'(got_q.size()), 32'(exp_q.size()));
            chk("rnd_err", 32'(n_err - r0), 32'(xerr));
            sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int i = 0; i < sz; i++)
                chk($sformatf("rnd_evt%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        set_ready(0);
        send_frame(8'h21, 0, 0);
        send_frame(8'h22, 0, 0);
        send_frame(8'h23, 0, 0);
        @(negedge clk);
        chk("mid_level3", 32'(fifo_level), 3);
        send_bits(8'h44, 0, 0, 6);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        set_ready(1);
        send_frame(8'h33, 0, 0);
        chk("post_rst_nevt", 32'(got_q.size()), 1);
        if (got_q.size() > 0)
            chk("post_rst_evt", 32'(got_q[0]), 32'h033);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_scan_event_rx.md
PS2_SCAN_EVENT_RX -- requirements
Module: ps2_scan_event_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: cycles a synchronised PS/2 line must hold a new level before the filtered line changes.
REQ-002 Parameter TIMEOUT_CYC, default 100000: CLOCK_50 cycles with no PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, minimum 2.
REQ-004 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 ps2_clk_in  in  1  raw PS/2 clock line, asynchronous to CLOCK_50.
REQ-007 ps2_dat_in  in  1  raw PS/2 data line, asynchronous to CLOCK_50.
REQ-008 evt_valid  out  1  FIFO head holds an event.
REQ-009 evt_ready  in  1  consumer accepts the head event.
REQ-010 evt_code  out  8  scan code of the head event.
REQ-011 evt_break  out  1  head event is a key release (F0-prefixed).
REQ-012 evt_ext  out  1  head event is extended (E0-prefixed).
REQ-013 fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently held.
REQ-014 overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
REQ-015 frame_err  out  1  one-cycle pulse when a frame is rejected.

Function
REQ-016 Each PS/2 input shall pass through a 2-FF synchroniser, then a FILTER_LEN stability filter; all logic below uses the filtered lines only.
REQ-017 A falling edge of the filtered clock shall be detected in the cycle after it appears and shall sample the filtered data line once.
REQ-018 Frame FSM states: IDLE, DATA, PARITY, STOP. IDLE->DATA on a sampled start bit of 0; a sampled 1 in IDLE is ignored.
REQ-019 DATA shall shift in 8 bits LSB-first, then go to PARITY; PARITY stores the bit and goes to STOP.
REQ-020 STOP: stop bit 1 -> byte accepted; stop bit 0 -> frame_err pulse, byte discarded; IDLE in both cases.
REQ-021 Any non-IDLE state with TIMEOUT_CYC cycles since the last falling edge shall return to IDLE, discard the partial byte, and leave frame_err low.
REQ-022 Decoder: byte E0 sets ext_pend, F0 sets brk_pend, and neither produces an event; any other byte produces event {ext_pend, brk_pend, byte}, then both pending flags clear.
REQ-023 An event shall be written to the FIFO in the cycle after the byte is accepted; evt_valid rises the following cycle when the FIFO was empty; there is no combinational bypass.
REQ-024 FIFO is first-word-fall-through: evt_code/evt_break/evt_ext show the head whenever evt_valid=1; the head pops on evt_valid&evt_ready.
REQ-025 evt_ready with evt_valid=0 shall have no effect.
REQ-026 Push while full without a same-cycle pop: event dropped, overflow pulses, FIFO contents unchanged.
REQ-027 Push and pop in the same cycle: both succeed, including when full; fifo_level unchanged.
REQ-028 Pointers wrap modulo FIFO_DEPTH; fifo_level ranges from 0 to FIFO_DEPTH inclusive.
REQ-029 Outputs evt_code, evt_break and evt_ext are don't-care while evt_valid=0.

Reset
REQ-030 RESET_N low shall asynchronously force: FSM IDLE, shift/bit counters 0, pending flags 0, timeout counter 0, FIFO empty, synchroniser and filter state 1 (idle-high lines).
REQ-031 Output reset values: evt_valid 0, evt_code 0, evt_break 0, evt_ext 0, fifo_level 0, overflow 0, frame_err 0.
REQ-032 Reset asserted mid-frame or with events queued shall discard all of them; after release, reception restarts at the next start bit.

Configuration
REQ-033 Macro PS2_PARITY_CHECK_EN defined: in STOP, odd-parity failure over 8 data bits plus parity bit shall reject the byte and pulse frame_err (same as a bad stop bit).
REQ-034 PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored; only the stop bit can cause frame_err.

Verification
REQ-035 Frame 0x1C, correct parity, evt_ready=1 -> one event code=1C, break=0, ext=0; fifo_level returns to 0.
REQ-036 Bytes E0,F0,75 -> exactly one event code=75, ext=1, break=1; a following byte 75 gives ext=0, break=0.
REQ-037 evt_ready=0, FIFO_DEPTH+1 frames sent -> fifo_level=FIFO_DEPTH, one overflow pulse; drained codes match the first FIFO_DEPTH frames in order.
REQ-038 Frame 0x1C with inverted parity -> frame_err pulse and no event with PS2_PARITY_CHECK_EN; event 1C without it.
REQ-039 Clock stopped after 4 data bits for TIMEOUT_CYC+10 cycles, then full frame 0x29 -> single event 29, no frame_err.
REQ-040 RESET_N pulsed low mid-frame with 3 events queued -> evt_valid=0 and fifo_level=0 immediately; the next complete frame is received correctly.
